// File: rtl/exec_mult_pipe.sv
// Pipelined integer multiplier execution unit.
// Issue enters slot 0, shifts one slot per advancing cycle and is handed off
// from the last slot. A wakeup tag is broadcast EARLY cycles before handoff.
// Mispredict flushes squash every in-flight entry younger than the branch,
// with age measured relative to the ROB head.
module exec_mult_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4,
    parameter int EARLY  = 1,
    parameter int TAG_W  = 6,
    parameter int ROB_W  = 5
) (
    input  logic                         clock,
    input  logic                         reset,

    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [1:0]                   in_func,
    input  logic [WIDTH-1:0]             in_opa,
    input  logic [WIDTH-1:0]             in_opb,
    input  logic [TAG_W-1:0]             in_dest_tag,
    input  logic [ROB_W-1:0]             in_rob_idx,

    input  logic                         flush_valid,
    input  logic [ROB_W-1:0]             flush_rob_idx,
    input  logic [ROB_W-1:0]             rob_head,

    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_value,
    output logic [TAG_W-1:0]             out_dest_tag,
    output logic [ROB_W-1:0]             out_rob_idx,

    output logic                         early_valid,
    output logic [TAG_W-1:0]             early_tag,

    output logic [$clog2(STAGES+1)-1:0]  occupancy
);

    localparam int LAST       = STAGES - 1;
    localparam int EARLY_SLOT = STAGES - 1 - EARLY;
    localparam int OCC_W      = $clog2(STAGES + 1);

    typedef enum logic [1:0] {
        FN_MUL    = 2'b00,  // low half
        FN_MULH   = 2'b01,  // high half, signed x signed
        FN_MULHSU = 2'b10,  // high half, signed x unsigned
        FN_MULHU  = 2'b11   // high half, unsigned x unsigned
    } func_e;

    // Slot state: valids carry reset, payload does not.
    logic [STAGES-1:0] valid_q;
    logic [TAG_W-1:0]  tag_q [STAGES];
    logic [ROB_W-1:0]  rob_q [STAGES];
    logic [WIDTH-1:0]  res_q [1:LAST];

    // Slot 0 keeps raw operands; the multiply happens on the way to slot 1.
    func_e             func_q;
    logic [WIDTH-1:0]  opa_q;
    logic [WIDTH-1:0]  opb_q;

    logic [STAGES-1:0] squash;
    logic              in_squash;
    logic              advance;
    logic              accept;
    logic              handoff;
    int                squash_cnt;
    int                occ_sum;

    logic [2*WIDTH-1:0] opa_ext;
    logic [2*WIDTH-1:0] opb_ext;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   result0;

    // True when idx is strictly younger than ref_idx, both measured from head.
    function automatic logic is_younger(input logic [ROB_W-1:0] idx,
                                        input logic [ROB_W-1:0] ref_idx,
                                        input logic [ROB_W-1:0] head);
        logic [ROB_W-1:0] age_idx;
        logic [ROB_W-1:0] age_ref;
        age_idx = idx - head;
        age_ref = ref_idx - head;
        return age_idx > age_ref;
    endfunction

    // Per-slot squash mask and its population count for occupancy.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        squash     = '0;
        squash_cnt = 0;
        for (int i = 0; i < STAGES; i++) begin
            squash[i]  = valid_q[i] && flush_valid &&
                         is_younger(rob_q[i], flush_rob_idx, rob_head);
            squash_cnt = squash_cnt + int'(squash[i]);
        end
    end

    // Handshake: a squashed tail cannot hold the pipe, a squashed issue is dropped.
    assign in_squash = flush_valid && is_younger(in_rob_idx, flush_rob_idx, rob_head);
    assign out_valid = valid_q[LAST] && !squash[LAST];
    assign advance   = !(out_valid && !out_ready);
    assign in_ready  = advance;
    assign accept    = in_valid && advance && !in_squash;
    assign handoff   = out_valid && out_ready;

    assign out_value    = res_q[LAST];
    assign out_dest_tag = tag_q[LAST];
    assign out_rob_idx  = rob_q[LAST];

    // The broadcast fires only when the slot moves on, so it happens exactly once.
    assign early_valid = valid_q[EARLY_SLOT] && !squash[EARLY_SLOT] && advance;
    assign early_tag   = tag_q[EARLY_SLOT];

    assign occ_sum = int'(occupancy) + int'(accept) - int'(handoff) - squash_cnt;

    // Operand extension by function, full-width product and half selection.
    always_comb begin
        opa_ext = {{WIDTH{1'b0}}, opa_q};
        opb_ext = {{WIDTH{1'b0}}, opb_q};
        if (func_q == FN_MULH || func_q == FN_MULHSU) begin
            opa_ext = {{WIDTH{opa_q[WIDTH-1]}}, opa_q};
        end
        if (func_q == FN_MULH) begin
            opb_ext = {{WIDTH{opb_q[WIDTH-1]}}, opb_q};
        end
        // Low 2*WIDTH bits of the extended product are exact for every sign mix.
        product = opa_ext * opb_ext;
        result0 = (func_q == FN_MUL) ? product[WIDTH-1:0] : product[2*WIDTH-1:WIDTH];
    end

    // Slot valids and occupancy: shift on advance, drop squashed entries at the edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // NOTE: sequential state is updated with non-blocking assignments only.
            valid_q   <= '0;
            occupancy <= '0;
        end else begin
            occupancy <= OCC_W'(occ_sum);
            if (advance) begin
                valid_q <= {valid_q[LAST-1:0] & ~squash[LAST-1:0], accept};
            end else begin
                valid_q <= valid_q & ~squash;
            end
        end
    end

    // Payload shift; qualified by valid_q so it never needs reset.
    always_ff @(posedge clock) begin
        // NOTE: payload arrays are left unreset; clearing them would add reset fan-out for nothing.
        if (advance) begin
            if (accept) begin
                func_q   <= func_e'(in_func);
                opa_q    <= in_opa;
                opb_q    <= in_opb;
                tag_q[0] <= in_dest_tag;
                rob_q[0] <= in_rob_idx;
            end
            res_q[1] <= result0;
            for (int i = 2; i < STAGES; i++) begin
                res_q[i] <= res_q[i-1];
            end
            for (int i = 1; i < STAGES; i++) begin
                tag_q[i] <= tag_q[i-1];
                rob_q[i] <= rob_q[i-1];
            end
        end
    end

endmodule

// File: tb/tb_exec_mult_pipe.sv
// Directed bench for exec_mult_pipe at default parameters.
module tb_exec_mult_pipe;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_func;
    logic [31:0] in_opa;
    logic [31:0] in_opb;
    logic [5:0]  in_dest_tag;
    logic [4:0]  in_rob_idx;
    logic        flush_valid;
    logic [4:0]  flush_rob_idx;
    logic [4:0]  rob_head;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_value;
    logic [5:0]  out_dest_tag;
    logic [4:0]  out_rob_idx;
    logic        early_valid;
    logic [5:0]  early_tag;
    logic [2:0]  occupancy;

    int compared   = 0;
    int mismatched = 0;

    exec_mult_pipe dut (
        .clock         (clock),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_func       (in_func),
        .in_opa        (in_opa),
        .in_opb        (in_opb),
        .in_dest_tag   (in_dest_tag),
        .in_rob_idx    (in_rob_idx),
        .flush_valid   (flush_valid),
        .flush_rob_idx (flush_rob_idx),
        .rob_head      (rob_head),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_value     (out_value),
        .out_dest_tag  (out_dest_tag),
        .out_rob_idx   (out_rob_idx),
        .early_valid   (early_valid),
        .early_tag     (early_tag),
        .occupancy     (occupancy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s: observed %0h required %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [1:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [5:0] t, input logic [4:0] r);
        in_valid    = v;
        in_func     = f;
        in_opa      = a;
        in_opb      = b;
        in_dest_tag = t;
        in_rob_idx  = r;
    endtask

    logic [31:0] mode_exp [4];
    logic [4:0]  wrap_rob [4];

    initial begin
        mode_exp = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
        wrap_rob = '{5'd30, 5'd31, 5'd0, 5'd1};

        reset         = 1'b1;
        set_in(1'b0, 2'd0, 32'd0, 32'd0, 6'd0, 5'd0);
        flush_valid   = 1'b0;
        flush_rob_idx = 5'd0;
        rob_head      = 5'd0;
        out_ready     = 1'b1;

        // Reset state
        tick(); tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_early_valid", early_valid, 0);
        check("rst_occupancy", occupancy, 0);
        reset = 1'b0;

        // Single MUL 7*6: broadcast in cycle 3, result in cycle 4
        tick();
        set_in(1'b1, 2'd0, 32'd7, 32'd6, 6'd5, 5'd3);
        #1;
        check("t1_in_ready", in_ready, 1);
        check("t1_occ0", occupancy, 0);
        tick();
        set_in(1'b0, 2'd0, 32'd0, 32'd0, 6'd0, 5'd0);
        #1;
        check("t1_c1_out_valid", out_valid, 0);
        check("t1_c1_early", early_valid, 0);
        check("t1_c1_occ", occupancy, 1);
        tick();
        check("t1_c2_early", early_valid, 0);
        tick();
        check("t1_c3_early", early_valid, 1);
        check("t1_c3_early_tag", early_tag, 5);
        check("t1_c3_out_valid", out_valid, 0);
        tick();
        check("t1_c4_out_valid", out_valid, 1);
        check("t1_c4_value", out_value, 42);
        check("t1_c4_tag", out_dest_tag, 5);
        check("t1_c4_rob", out_rob_idx, 3);
        check("t1_c4_early", early_valid, 0);
        tick();
        check("t1_c5_out_valid", out_valid, 0);
        check("t1_c5_occ", occupancy, 0);

        // All four functions back to back on 0xFFFFFFFF * 2
        for (int i = 0; i < 4; i++) begin
            tick();
            set_in(1'b1, 2'(i), 32'hFFFF_FFFF, 32'd2, 6'(i + 1), 5'(i + 4));
            #1;
            check("t2_in_ready", in_ready, 1);
        end
        tick();
        set_in(1'b0, 2'd0, 32'd0, 32'd0, 6'd0, 5'd0);
        #1;
        for (int j = 0; j < 4; j++) begin
            check("t2_out_valid", out_valid, 1);
            check("t2_value", out_value, mode_exp[j]);
            check("t2_rob", out_rob_idx, 5'(j + 4));
            tick();
        end
        check("t2_drained", out_valid, 0);

        // Fill four, stall three cycles, release
        for (int i = 0; i < 4; i++) begin
            tick();
            set_in(1'b1, 2'd0, 32'(i + 1), 32'd10, 6'(10 + i), 5'(8 + i));
            #1;
        end
        tick();
        set_in(1'b0, 2'd0, 32'd0, 32'd0, 6'd0, 5'd0);
        out_ready = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) tick();
            check("t3_stall_in_ready", in_ready, 0);
            check("t3_stall_out_valid", out_valid, 1);
            check("t3_stall_value", out_value, 10);
            check("t3_stall_occ", occupancy, 4);
            check("t3_stall_early", early_valid, 0);
        end
        tick();
        out_ready = 1'b1;
        #1;
        check("t3_full_in_ready", in_ready, 1);
        check("t3_full_occ", occupancy, 4);
        for (int j = 0; j < 4; j++) begin
            check("t3_rel_out_valid", out_valid, 1);
            check("t3_rel_value", out_value, 32'(10 * (j + 1)));
            check("t3_rel_tag", out_dest_tag, 6'(10 + j));
            tick();
        end
        check("t3_end_out_valid", out_valid, 0);
        check("t3_end_occ", occupancy, 0);

        // Flush with ROB index wrap: head 30, branch 31 kills 0 and 1
        rob_head = 5'd30;
        for (int i = 0; i < 4; i++) begin
            tick();
            set_in(1'b1, 2'd0, 32'(i + 2), 32'd3, 6'(20 + i), wrap_rob[i]);
            #1;
        end
        tick();
        set_in(1'b0, 2'd0, 32'd0, 32'd0, 6'd0, 5'd0);
        flush_valid   = 1'b1;
        flush_rob_idx = 5'd31;
        #1;
        check("t4_c4_out_valid", out_valid, 1);
        check("t4_c4_value", out_value, 6);
        check("t4_c4_rob", out_rob_idx, 30);
        check("t4_c4_early", early_valid, 1);
        check("t4_c4_early_tag", early_tag, 21);
        check("t4_c4_occ", occupancy, 4);
        tick();
        flush_valid = 1'b0;
        #1;
        check("t4_c5_out_valid", out_valid, 1);
        check("t4_c5_value", out_value, 9);
        check("t4_c5_rob", out_rob_idx, 31);
        check("t4_c5_occ", occupancy, 1);
        check("t4_c5_early", early_valid, 0);
        tick();
        check("t4_c6_out_valid", out_valid, 0);
        check("t4_c6_occ", occupancy, 0);
        tick();
        check("t4_c7_out_valid", out_valid, 0);

        // Flush hitting the tail slot, plus a squashed issue in the same cycle
        rob_head = 5'd0;
        tick();
        set_in(1'b1, 2'd0, 32'd5, 32'd5, 6'd30, 5'd2);
        #1;
        tick();
        set_in(1'b0, 2'd0, 32'd0, 32'd0, 6'd0, 5'd0);
        #1;
        tick();
        tick();
        tick();
        flush_valid   = 1'b1;
        flush_rob_idx = 5'd1;
        set_in(1'b1, 2'd0, 32'd9, 32'd9, 6'd31, 5'd3);
        #1;
        check("t5_out_valid", out_valid, 0);
        check("t5_early", early_valid, 0);
        check("t5_occ", occupancy, 1);
        check("t5_in_ready", in_ready, 1);
        tick();
        set_in(1'b0, 2'd0, 32'd0, 32'd0, 6'd0, 5'd0);
        flush_valid = 1'b0;
        #1;
        check("t5_after_occ", occupancy, 0);
        check("t5_after_out_valid", out_valid, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t5_no_result", out_valid, 0);
        end

        // Reset with three entries in flight
        for (int i = 0; i < 3; i++) begin
            tick();
            set_in(1'b1, 2'd0, 32'(i + 1), 32'd1, 6'(40 + i), 5'(i));
            #1;
        end
        tick();
        set_in(1'b0, 2'd0, 32'd0, 32'd0, 6'd0, 5'd0);
        #1;
        check("t6_pre_early", early_valid, 1);
        check("t6_pre_early_tag", early_tag, 40);
        check("t6_pre_occ", occupancy, 3);
        reset = 1'b1;
        #1;
        check("t6_rst_out_valid", out_valid, 0);
        check("t6_rst_early", early_valid, 0);
        check("t6_rst_occ", occupancy, 0);
        check("t6_rst_in_ready", in_ready, 1);
        tick();
        tick();
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("t6_post_out_valid", out_valid, 0);
            check("t6_post_early", early_valid, 0);
        end
        check("t6_post_occ", occupancy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/exec_mult_pipe.md
EXEC_MULT_PIPE -- requirements
Module: exec_mult_pipe

Interface
REQ-001 Parameter WIDTH, 32, operand/result width.
REQ-002 Parameter STAGES, 4, pipeline depth in cycles, legal range 2..8.
REQ-003 Parameter EARLY, 1, cycles of early tag broadcast ahead of result handoff, legal range 0..STAGES-1.
REQ-004 Parameter TAG_W, 6, physical tag width.
REQ-005 Parameter ROB_W, 5, ROB index width.
REQ-006 The block SHALL use one clock and an asynchronous active-high reset, with ports clock and reset.
REQ-007 clock  in  1  sole clock, rising edge.
REQ-008 reset  in  1  asynchronous, active-high.
REQ-009 in_valid  in  1  issue request.
REQ-010 in_ready  out  1  block accepts this cycle.
REQ-011 in_func  in  2  00 MUL low, 01 MULH s*s, 10 MULHSU s*u, 11 MULHU u*u.
REQ-012 in_opa, in_opb  in  WIDTH each  operands (opa signed for 01/10).
REQ-013 in_dest_tag  in  TAG_W; in_rob_idx  in  ROB_W.
REQ-014 flush_valid  in  1; flush_rob_idx  in  ROB_W; rob_head  in  ROB_W  mispredict squash request and age reference.
REQ-015 out_valid  out  1; out_ready  in  1; out_value  out  WIDTH; out_dest_tag  out  TAG_W; out_rob_idx  out  ROB_W.
REQ-016 early_valid  out  1; early_tag  out  TAG_W  wakeup broadcast.
REQ-017 occupancy  out  clog2(STAGES+1)  count of valid in-flight entries.

Function
REQ-018 Pipeline: slots s[0..STAGES-1]; s[STAGES-1] drives out_*; advance = !(s[STAGES-1].valid && !out_ready).
REQ-019 in_ready SHALL equal advance (combinational); accept = in_valid && in_ready writes s[0].
REQ-020 On advance, every slot shifts by one; when advance is 0 all slots hold (whole-pipe stall, no bubble collapsing).
REQ-021 Latency: accept at edge k SHALL give out_valid in the cycle after edge k+STAGES-1 absent stalls; each stall cycle adds exactly one.
REQ-022 Throughput: one accept per cycle with out_ready held high.
REQ-023 out_value: 2*WIDTH product of extended operands; func 00 bits [WIDTH-1:0], else [2*WIDTH-1:WIDTH]; multiply partitioning across stages is free provided REQ-021 holds.
REQ-024 early_valid = s[STAGES-1-EARLY].valid && advance && not squashed; early_tag from that slot; each instruction broadcasts exactly once; with EARLY=0 this coincides with the handoff cycle.
REQ-025 A broadcast is never retracted; a later stall only delays out_valid.
REQ-026 Age: age(x) = (x - rob_head) mod 2^ROB_W; entry squashed when flush_valid && age(entry) > age(flush_rob_idx); the branch itself is kept.
REQ-027 In the flush cycle, squashed slots SHALL be masked combinationally from out_valid, early_valid and accept (a squashed in_* is not written); they are cleared at the edge.
REQ-028 Flush SHALL NOT alter advance computed from unsquashed state except via the masked out_valid.
REQ-029 occupancy SHALL be registered and updated each edge as +accept -handoff -squashed count; never exceeds STAGES.
REQ-030 Simultaneous accept and handoff with no squash leaves occupancy unchanged.
REQ-031 Full pipe with out_ready=1 SHALL still accept (in_ready=1).

Reset
REQ-032 While reset is high, all slot valids SHALL be 0; out_valid=0, early_valid=0, occupancy=0, in_ready=1; data fields are don't-care.
REQ-033 Reset asserted mid-operation SHALL discard all in-flight entries with no broadcast or handoff afterwards.

Verification
REQ-034 Default params, accept MUL 7*6 tag 5 rob 3, out_ready=1 -> early_valid tag 5 in cycle 3 after accept, out_valid value 42 in cycle 4.
REQ-035 Modes: opa=0xFFFFFFFF, opb=2 -> 00:0xFFFFFFFE, 01:0xFFFFFFFF, 10:0xFFFFFFFF, 11:0x00000001.
REQ-036 Fill 4 back-to-back, hold out_ready=0 three cycles -> in_ready=0, out_value frozen, occupancy=4; release -> four results in order, one per cycle.
REQ-037 rob_head=30, in-flight rob 30,31,0,1, flush_rob_idx=31 -> entries 0 and 1 removed (wrap), 30 and 31 complete, occupancy drops by 2.
REQ-038 Flush in the cycle s[3] holds a younger entry with out_ready=1 -> out_valid=0 that cycle, no handoff.
REQ-039 Reset asserted with 3 entries in flight -> out_valid/early_valid 0 immediately, occupancy 0, no result after release.
